// File: rtl/third_row_enemy_sequencer.sv
// third_row_enemy_sequencer: owns one third-row enemy's alive flag, position and movement phase.
// Defining ENEMY_PAUSE_EN adds i_Pause, which freezes frame-tick stepping.
module third_row_enemy_sequencer #(
    parameter logic [18:0] NONE              = 19'h7FFFF,
    parameter logic [8:0]  VERTICAL_POSITION = 9'd168,
    parameter logic [9:0]  INIT_X            = 10'd320,
    parameter logic [7:0]  STEP_DIV          = 8'd4,
    parameter logic [7:0]  PHASE_STEPS       = 8'd32
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_FrameTick,
    input  logic        i_Hit,
    input  logic [18:0] i_NextPosition,
`ifdef ENEMY_PAUSE_EN
    input  logic        i_Pause,
`endif
    output logic        o_EnemyState,
    output logic [18:0] o_EnemyPosition,
    output logic [1:0]  o_PhaseState,
    output logic        o_StepStrobe
);
    logic [7:0] tickDiv;
    logic [7:0] stepCount;
    logic       run;
    logic       step;
    logic       phaseWrap;
`ifdef ENEMY_PAUSE_EN
    assign run = i_FrameTick && !i_Pause;
`else
    assign run = i_FrameTick;
`endif
    assign step      = run && (tickDiv == STEP_DIV - 8'd1);
    assign phaseWrap = stepCount == PHASE_STEPS - 8'd1;
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_EnemyState    <= 1'b1;
            o_EnemyPosition <= {INIT_X, VERTICAL_POSITION};
            o_PhaseState    <= 2'b00;
            o_StepStrobe    <= 1'b0;
            tickDiv         <= 8'd0;
            stepCount       <= 8'd0;
        end else begin
            o_StepStrobe <= step;
            if (run)
                tickDiv <= step ? 8'd0 : tickDiv + 8'd1;
            if (step) begin
                stepCount <= phaseWrap ? 8'd0 : stepCount + 8'd1;
                if (phaseWrap)
                    o_PhaseState <= o_PhaseState + 2'd1;
            end
            // a hit beats a coincident step; a dead enemy never reloads its position
            if (o_EnemyState && i_Hit) begin
                o_EnemyState    <= 1'b0;
                o_EnemyPosition <= NONE;
            end else if (o_EnemyState && step) begin
                o_EnemyPosition <= i_NextPosition;
            end
        end
    end
endmodule

// File: tb/tb_third_row_enemy_sequencer.sv
// tb_third_row_enemy_sequencer: scoreboard bench with a behavioural third-row move block in the loop.
module tb_third_row_enemy_sequencer;
    localparam logic [18:0] NONE = 19'h7FFFF;
    typedef struct packed {
        logic        strobe;
        logic        state;
        logic [18:0] pos;
        logic [1:0]  phase;
    } exp_t;

    logic        clk = 0;
    logic        reset = 0;
    logic        frameTick = 0;
    logic        hitIn = 0;
    logic        pause = 0;
    logic [18:0] nextPos;
    logic        enemyState;
    logic [18:0] enemyPos;
    logic [1:0]  phaseState;
    logic        stepStrobe;

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    exp_t e;

    logic        mAlive;
    logic [18:0] mPos;
    logic [1:0]  mPhase;
    logic [7:0]  mDiv;
    logic [7:0]  mStep;

    always #5 clk = ~clk;

    // third-row move block: phases 00/11 step left, 01/10 step right
    always_comb begin
        nextPos = NONE;
        if (enemyState)
            nextPos = {enemyPos[18:9] + ((phaseState == 2'd1 || phaseState == 2'd2) ? 10'd1 : 10'h3FF), enemyPos[8:0]};
    end

    third_row_enemy_sequencer dut (
        .i_Clk(clk),
        .i_Reset(reset),
        .i_FrameTick(frameTick),
        .i_Hit(hitIn),
        .i_NextPosition(nextPos),
`ifdef ENEMY_PAUSE_EN
        .i_Pause(pause),
`endif
        .o_EnemyState(enemyState),
        .o_EnemyPosition(enemyPos),
        .o_PhaseState(phaseState),
        .o_StepStrobe(stepStrobe)
    );

    task automatic drive(input logic ft, input logic hit, input logic rst);
        logic       st;
        logic [9:0] x;
        frameTick = ft;
        hitIn     = hit;
        reset     = rst;
        st        = 1'b0;
        if (rst) begin
            mAlive = 1'b1;
            mPos   = {10'd320, 9'd168};
            mPhase = 2'd0;
            mDiv   = 8'd0;
            mStep  = 8'd0;
        end else begin
            st = ft && !pause && mDiv == 8'd3;
            if (ft && !pause)
                mDiv = st ? 8'd0 : mDiv + 8'd1;
            x = mPos[18:9] + ((mPhase == 2'd1 || mPhase == 2'd2) ? 10'd1 : 10'h3FF);
            if (mAlive && hit) begin
                mAlive = 1'b0;
                mPos   = NONE;
            end else if (mAlive && st) begin
                mPos = {x, 9'd168};
            end
            if (st) begin
                if (mStep == 8'd31) begin
                    mStep  = 8'd0;
                    mPhase = mPhase + 2'd1;
                end else begin
                    mStep = mStep + 8'd1;
                end
            end
        end
        q.push_back('{st, mAlive, mPos, mPhase});
        @(posedge clk);
        #1;
        frameTick = 0;
        hitIn     = 0;
        reset     = 0;
    endtask

    task automatic test_reset;
        drive(0, 0, 1);
        e = q.pop_front();
        tests++;
        if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
            fails++;
            $display("FAIL reset_sb: got %h expected %h", {stepStrobe, enemyState, enemyPos, phaseState}, e);
        end
        tests++;
        if (enemyPos !== {10'd320, 9'd168} || phaseState !== 2'b00 || enemyState !== 1'b1 || stepStrobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: got pos=%h phase=%0d state=%0b strobe=%0b expected pos=%h phase=0 state=1 strobe=0",
                     enemyPos, phaseState, enemyState, stepStrobe, {10'd320, 9'd168});
        end
    endtask

    task automatic test_full_cycle;
        drive(0, 0, 1);
        void'(q.pop_front());
        for (int t = 1; t <= 1024; t++) begin
            drive(1, 0, 0);
            e = q.pop_front();
            tests++;
            if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
                fails++;
                $display("FAIL full_cycle_sb tick %0d: got %h expected %h", t, {stepStrobe, enemyState, enemyPos, phaseState}, e);
            end
            if (t == 128 || t == 384 || t == 512 || t == 1024) begin
                tests++;
                if ((t == 128 && (enemyPos[18:9] !== 10'd288 || phaseState !== 2'd1)) ||
                    (t == 384 && (enemyPos[18:9] !== 10'd352 || phaseState !== 2'd3)) ||
                    ((t == 512 || t == 1024) && (enemyPos[18:9] !== 10'd320 || phaseState !== 2'd0))) begin
                    fails++;
                    $display("FAIL full_cycle_milestone tick %0d: got x=%0d phase=%0d", t, enemyPos[18:9], phaseState);
                end
            end
        end
    endtask

    task automatic test_cadence;
        int ticks;
        int strobes;
        logic ft;
        ticks   = 0;
        strobes = 0;
        drive(0, 0, 1);
        void'(q.pop_front());
        for (int c = 0; c < 200; c++) begin
            ft = 1'($urandom_range(0, 1));
            drive(ft, 0, 0);
            ticks += int'(ft);
            strobes += int'(stepStrobe);
            e = q.pop_front();
            tests++;
            if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
                fails++;
                $display("FAIL cadence_sb cycle %0d: got %h expected %h", c, {stepStrobe, enemyState, enemyPos, phaseState}, e);
            end
            tests++;
            if (stepStrobe !== (ft && ticks % 4 == 0)) begin
                fails++;
                $display("FAIL cadence_strobe cycle %0d: got %0b expected %0b", c, stepStrobe, ft && ticks % 4 == 0);
            end
        end
        tests++;
        if (strobes != ticks / 4) begin
            fails++;
            $display("FAIL cadence_count: got %0d strobes expected %0d", strobes, ticks / 4);
        end
    endtask

    task automatic test_hit_on_step;
        logic [1:0] firstPhase;
        drive(0, 0, 1);
        void'(q.pop_front());
        for (int t = 1; t <= 240; t++) begin
            drive(1, (t == 40) || (t == 150), 0);
            e = q.pop_front();
            tests++;
            if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
                fails++;
                $display("FAIL hit_sb tick %0d: got %h expected %h", t, {stepStrobe, enemyState, enemyPos, phaseState}, e);
            end
            if (t == 40) begin
                firstPhase = phaseState;
                tests++;
                if (enemyPos !== NONE || enemyState !== 1'b0 || stepStrobe !== 1'b1) begin
                    fails++;
                    $display("FAIL hit_step10: got pos=%h state=%0b strobe=%0b expected pos=%h state=0 strobe=1",
                             enemyPos, enemyState, stepStrobe, NONE);
                end
            end
        end
        tests++;
        if (phaseState === firstPhase || enemyPos !== NONE || enemyState !== 1'b0) begin
            fails++;
            $display("FAIL hit_dead_after: got phase=%0d pos=%h state=%0b expected phase!=%0d pos=%h state=0",
                     phaseState, enemyPos, enemyState, firstPhase, NONE);
        end
    endtask

    task automatic test_reset_mid_phase;
        drive(0, 0, 1);
        void'(q.pop_front());
        for (int t = 1; t <= 326; t++) begin
            drive(1, 0, 0);
            e = q.pop_front();
            tests++;
            if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
                fails++;
                $display("FAIL midreset_sb tick %0d: got %h expected %h", t, {stepStrobe, enemyState, enemyPos, phaseState}, e);
            end
        end
        tests++;
        if (phaseState !== 2'd2) begin
            fails++;
            $display("FAIL midreset_phase: got %0d expected 2", phaseState);
        end
        drive(1, 0, 1);
        e = q.pop_front();
        tests++;
        if (enemyPos !== {10'd320, 9'd168} || phaseState !== 2'd0 || enemyState !== 1'b1 || stepStrobe !== 1'b0) begin
            fails++;
            $display("FAIL midreset_values: got pos=%h phase=%0d state=%0b strobe=%0b", enemyPos, phaseState, enemyState, stepStrobe);
        end
        for (int t = 1; t <= 4; t++) begin
            drive(1, 0, 0);
            e = q.pop_front();
            tests++;
            if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
                fails++;
                $display("FAIL midreset_post_sb tick %0d: got %h expected %h", t, {stepStrobe, enemyState, enemyPos, phaseState}, e);
            end
        end
        tests++;
        if (enemyPos[18:9] !== 10'd319 || stepStrobe !== 1'b1) begin
            fails++;
            $display("FAIL midreset_first_step: got x=%0d strobe=%0b expected x=319 strobe=1", enemyPos[18:9], stepStrobe);
        end
    endtask

`ifdef ENEMY_PAUSE_EN
    task automatic test_pause;
        drive(0, 0, 1);
        void'(q.pop_front());
        for (int t = 1; t <= 6; t++) begin
            drive(1, 0, 0);
            void'(q.pop_front());
        end
        pause = 1;
        for (int t = 1; t <= 50; t++) begin
            drive(1, t == 25, 0);
            e = q.pop_front();
            tests++;
            if ({stepStrobe, enemyState, enemyPos, phaseState} !== e) begin
                fails++;
                $display("FAIL pause_sb tick %0d: got %h expected %h", t, {stepStrobe, enemyState, enemyPos, phaseState}, e);
            end
            tests++;
            if (stepStrobe !== 1'b0 || phaseState !== 2'd0 || (t < 25 && enemyPos[18:9] !== 10'd319)) begin
                fails++;
                $display("FAIL pause_hold tick %0d: got strobe=%0b phase=%0d x=%0d", t, stepStrobe, phaseState, enemyPos[18:9]);
            end
        end
        pause = 0;
        tests++;
        if (enemyState !== 1'b0 || enemyPos !== NONE) begin
            fails++;
            $display("FAIL pause_hit: got state=%0b pos=%h expected state=0 pos=%h", enemyState, enemyPos, NONE);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_cycle();
        test_cadence();
        test_hit_on_step();
        test_reset_mid_phase();
`ifdef ENEMY_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
